// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: width codes, FSM
// state encodings, wait-counter width and access-size helpers.
package mem_access_unit_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam int CNT_W = 8;

    // Byte-enable mask of an access at offset 0; the unused code 2'b11 acts as a word.
    function automatic logic [7:0] size_mask(input logic [1:0] width);
        case (width)
            W_BYTE:  return 8'h01;
            W_HALF:  return 8'h03;
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        return ((width == W_HALF) && (off == 2'd3)) ||
               ((width != W_BYTE) && (width != W_HALF) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_access_unit_dmem_lane_shift.sv
// Byte-lane steering for the access stage: store strobes/data across the
// two-word window and load extraction with zero/sign extension.
module dmem_lane_shift
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  width_i,
    input  logic        zext_i,
    input  logic        phase_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [4:0]  shamt;
    logic [7:0]  strb8;
    logic [63:0] data64;
    logic [31:0] window;

    always_comb begin
        shamt  = {offset_i, 3'b000};
        strb8  = size_mask(width_i) << offset_i;
        data64 = {32'h0, store_data_i} << shamt;
        window = 32'({word1_i, word0_i} >> shamt);

        // phase_i selects the second word of a split access.
        wstrb_o = phase_i ? strb8[7:4]    : strb8[3:0];
        wdata_o = phase_i ? data64[63:32] : data64[31:0];

        case (width_i)
            W_BYTE:  load_data_o = {{24{~zext_i & window[7]}},  window[7:0]};
            W_HALF:  load_data_o = {{16{~zext_i & window[15]}}, window[15:0]};
            default: load_data_o = window;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage on a req/ack bus with wait-state timeout and faults.
// Define MEM_MISALIGNED_SPLIT_EN to split misaligned accesses instead of trapping.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mb__valid,
    input  logic [ADDR_W-1:0] ex_mb__alu_y,
    input  logic [31:0]       ex_mb__rs2_rdata,
    input  logic [1:0]        ex_mb__dmem_width,
    input  logic              ex_mb__dmem_zero_ext,
    input  logic              ex_mb__dmem_read,
    input  logic              ex_mb__dmem_write,
    output logic              mb_ex__stall,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_wstrb,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic              dbus_err,
    input  logic [31:0]       dbus_rdata,
    output logic              mb_wb__valid,
    output logic [31:0]       mb_wb__rdata,
    output logic              mb_wb__fault,
    output logic              mb_wb__misaligned
);

`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        width_q, width_d;
    logic              zext_q, zext_d, we_q, we_d, split_q, split_d;
    logic [31:0]       word0_q, word0_d, rdata_q, rdata_d;
    logic              fault_q, fault_d, mis_q, mis_d;

    logic              accept, acc_mis, acc_active, in_acc1, in_resp;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata, load_data, ld_word0, ld_word1;

    assign accept     = (state_q == ST_IDLE) && ex_mb__valid &&
                        (ex_mb__dmem_read || ex_mb__dmem_write);
    assign acc_mis    = is_misaligned(ex_mb__dmem_width, ex_mb__alu_y[1:0]);
    assign acc_active = (state_q == ST_ACC0) || (state_q == ST_ACC1);
    assign in_acc1    = (state_q == ST_ACC1);
    assign in_resp    = (state_q == ST_RESP);

    assign mb_ex__stall = accept || acc_active;

    assign base_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dbus_req   = acc_active;
    assign dbus_we    = acc_active && we_q;
    assign dbus_addr  = !acc_active ? '0 : (in_acc1 ? base_addr + ADDR_W'(4) : base_addr);
    assign dbus_wstrb = dbus_we ? lane_wstrb : 4'h0;
    assign dbus_wdata = dbus_we ? lane_wdata : 32'h0;

    // The load window is assembled at the final ack: word0 is live on the bus
    // for an unsplit access and comes from the capture register after ACC1.
    assign ld_word0 = in_acc1 ? word0_q : dbus_rdata;
    assign ld_word1 = in_acc1 ? dbus_rdata : 32'h0;

    assign mb_wb__valid      = in_resp;
    assign mb_wb__rdata      = in_resp ? rdata_q : 32'h0;
    assign mb_wb__fault      = in_resp && fault_q;
    assign mb_wb__misaligned = in_resp && mis_q;

    dmem_lane_shift u_lane (
        .offset_i     (addr_q[1:0]),
        .width_i      (width_q),
        .zext_i       (zext_q),
        .phase_i      (in_acc1),
        .store_data_i (wdata_q),
        .word0_i      (ld_word0),
        .word1_i      (ld_word1),
        .wstrb_o      (lane_wstrb),
        .wdata_o      (lane_wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        width_d = width_q;
        zext_d  = zext_q;
        we_d    = we_q;
        split_d = split_q;
        word0_d = word0_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        mis_d   = mis_q;
        cnt_inc = cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = ex_mb__alu_y;
                    wdata_d = ex_mb__rs2_rdata;
                    width_d = ex_mb__dmem_width;
                    zext_d  = ex_mb__dmem_zero_ext;
                    we_d    = ex_mb__dmem_write;
                    split_d = acc_mis && SPLIT_EN;
                    mis_d   = acc_mis && !SPLIT_EN;
                    fault_d = 1'b0;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    state_d = (acc_mis && !SPLIT_EN) ? ST_RESP : ST_ACC0;
                end
            end
            ST_ACC0, ST_ACC1: begin
                // err beats ack, and ack beats the timeout.
                if (dbus_err) begin
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = ST_RESP;
                end else if (dbus_ack) begin
                    cnt_d = '0;
                    if (!in_acc1) word0_d = dbus_rdata;
                    if (!in_acc1 && split_q) begin
                        state_d = ST_ACC1;
                    end else begin
                        rdata_d = we_q ? 32'h0 : load_data;
                        state_d = ST_RESP;
                    end
                end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            width_q <= W_BYTE;
            zext_q  <= 1'b0;
            we_q    <= 1'b0;
            split_q <= 1'b0;
            word0_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            zext_q  <= zext_d;
            we_q    <= we_d;
            split_q <= split_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// non-memory sequences, then randomized ops against a byte-level model.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 15;
`ifdef MEM_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    localparam logic [1:0] K_ACK = 2'd0, K_ERR = 2'd1, K_ERRACK = 2'd2, K_NONE = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic        zext, rd, wr;
        logic [31:0] word0, word1;
        logic [7:0]  wait0, wait1;
        logic [1:0]  kind0, kind1;
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] rdata;
        logic        fault, mis;
        logic [1:0]  ntxn;
        logic [31:0] addr0;
        logic [3:0]  wstrb0;
        logic [31:0] wdata0;
    } vec_t;

    typedef struct packed {
        logic [31:0]      rdata;
        logic             fault, mis, we;
        int               ntxn, req_cycles;
        logic [1:0][31:0] addr;
        logic [1:0][3:0]  wstrb;
        logic [1:0][31:0] wdata;
    } exp_t;

    logic clk, rst_n;
    logic ex_mb__valid, ex_mb__dmem_zero_ext, ex_mb__dmem_read, ex_mb__dmem_write;
    logic [31:0] ex_mb__alu_y, ex_mb__rs2_rdata;
    logic [1:0]  ex_mb__dmem_width;
    logic mb_ex__stall, dbus_req, dbus_we, dbus_ack, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, mb_wb__rdata;
    logic [3:0]  dbus_wstrb;
    logic mb_wb__valid, mb_wb__fault, mb_wb__misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] obs_rdata, obs_addr0, obs_wdata0;
    logic        obs_fault, obs_mis;
    logic [3:0]  obs_wstrb0;
    int          obs_ntxn;

    mem_access_unit #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ex_mb__valid         (ex_mb__valid),
        .ex_mb__alu_y         (ex_mb__alu_y),
        .ex_mb__rs2_rdata     (ex_mb__rs2_rdata),
        .ex_mb__dmem_width    (ex_mb__dmem_width),
        .ex_mb__dmem_zero_ext (ex_mb__dmem_zero_ext),
        .ex_mb__dmem_read     (ex_mb__dmem_read),
        .ex_mb__dmem_write    (ex_mb__dmem_write),
        .mb_ex__stall         (mb_ex__stall),
        .dbus_req             (dbus_req),
        .dbus_we              (dbus_we),
        .dbus_addr            (dbus_addr),
        .dbus_wstrb           (dbus_wstrb),
        .dbus_wdata           (dbus_wdata),
        .dbus_ack             (dbus_ack),
        .dbus_err             (dbus_err),
        .dbus_rdata           (dbus_rdata),
        .mb_wb__valid         (mb_wb__valid),
        .mb_wb__rdata         (mb_wb__rdata),
        .mb_wb__fault         (mb_wb__fault),
        .mb_wb__misaligned    (mb_wb__misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] addr, data, input logic [1:0] width,
                                  input logic zext, rd, wr, input logic [31:0] w0, w1,
                                  input int wt0, input logic [1:0] k0,
                                  input int wt1, input logic [1:0] k1);
        op_t o;
        o.addr = addr;  o.data = data;  o.width = width;
        o.zext = zext;  o.rd = rd;      o.wr = wr;
        o.word0 = w0;   o.word1 = w1;
        o.wait0 = 8'(wt0); o.kind0 = k0;
        o.wait1 = 8'(wt1); o.kind1 = k1;
        return o;
    endfunction

    function automatic vec_t mk_vec(input op_t op, input logic [31:0] rdata, input logic fault, mis,
                                    input int ntxn, input logic [31:0] addr0,
                                    input logic [3:0] wstrb0, input logic [31:0] wdata0);
        vec_t v;
        v.op = op; v.rdata = rdata; v.fault = fault; v.mis = mis; v.ntxn = 2'(ntxn);
        v.addr0 = addr0; v.wstrb0 = wstrb0; v.wdata0 = wdata0;
        return v;
    endfunction

    // Byte-level reference: what the bus should see and what writeback should get.
    function automatic exp_t model(input op_t op);
        exp_t e;
        int size, off, pos, planned;
        logic mis;
        logic [1:0] kind;
        logic [7:0] wt;
        logic [31:0] v;
        e = '0;
        size = (op.width == 2'b00) ? 1 : (op.width == 2'b01) ? 2 : 4;
        off  = int'(op.addr[1:0]);
        mis  = (size == 2 && off == 3) || (size == 4 && off != 0);
        e.we  = op.wr;
        e.mis = mis && !SPLIT;
        planned = !mis ? 1 : (SPLIT ? 2 : 0);
        for (int t = 0; t < 2; t++) e.addr[t] = {op.addr[31:2], 2'b00} + 32'(4 * t);
        for (int i = 0; i < 8; i++) begin
            if (op.wr && i >= off && i < off + size) e.wstrb[i / 4][i % 4] = 1'b1;
            if (op.wr && i >= off && i < off + 4) e.wdata[i / 4][8 * (i % 4) +: 8] = op.data[8 * (i - off) +: 8];
        end
        for (int t = 0; t < planned; t++) begin
            kind = (t == 0) ? op.kind0 : op.kind1;
            wt   = (t == 0) ? op.wait0 : op.wait1;
            e.ntxn++;
            e.req_cycles += (kind == K_NONE) ? MAX_WAIT : int'(wt) + 1;
            if (kind != K_ACK) begin
                e.fault = 1'b1;
                break;
            end
        end
        if (!e.fault && !op.wr && !e.mis) begin
            v = '0;
            for (int j = 0; j < size; j++) begin
                pos = off + j;
                v[8 * j +: 8] = (pos < 4) ? op.word0[8 * pos +: 8] : op.word1[8 * (pos - 4) +: 8];
            end
            if (!op.zext)
                for (int j = 8 * size; j < 32; j++) v[j] = v[8 * size - 1];
            e.rdata = v;
        end
        return e;
    endfunction

    // Drives one instruction, plays the bus responder, and checks against the model.
    task automatic run_op(input string name, input op_t op);
        exp_t e;
        int k, cyc, idx, reqc, stallc, exp_lat;
        logic in_txn, bad, done;
        logic [1:0] kind;
        logic [7:0] wt;
        e = model(op);
        k = 0; cyc = 0; idx = 0; reqc = 0; stallc = 0;
        in_txn = 1'b0; bad = 1'b0; done = 1'b0;
        obs_ntxn = 0; obs_rdata = '0; obs_fault = 1'b0; obs_mis = 1'b0;
        obs_addr0 = '0; obs_wstrb0 = '0; obs_wdata0 = '0;
        @(negedge clk);
        ex_mb__valid = 1'b1;          ex_mb__alu_y = op.addr;
        ex_mb__rs2_rdata = op.data;   ex_mb__dmem_width = op.width;
        ex_mb__dmem_zero_ext = op.zext;
        ex_mb__dmem_read = op.rd;     ex_mb__dmem_write = op.wr;
        while (!done && k < 300) begin
            #1;
            dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = 32'h0;
            if (mb_ex__stall) stallc++;
            if (mb_wb__valid) begin
                obs_rdata = mb_wb__rdata;
                obs_fault = mb_wb__fault;
                obs_mis   = mb_wb__misaligned;
                done = 1'b1;
                ex_mb__valid = 1'b0;
            end else if (dbus_req) begin
                reqc++;
                if (!in_txn) begin
                    in_txn = 1'b1; cyc = 0; idx = obs_ntxn; obs_ntxn++;
                    if (idx == 0) begin
                        obs_addr0 = dbus_addr; obs_wstrb0 = dbus_wstrb; obs_wdata0 = dbus_wdata;
                    end
                end
                if (idx < 2)
                    bad |= (dbus_addr !== e.addr[idx]) || (dbus_we !== e.we) ||
                           (dbus_wstrb !== e.wstrb[idx]) || (dbus_wdata !== e.wdata[idx]);
                else
                    bad = 1'b1;
                kind = (idx == 0) ? op.kind0 : op.kind1;
                wt   = (idx == 0) ? op.wait0 : op.wait1;
                if (kind != K_NONE && cyc == int'(wt)) begin
                    dbus_ack   = (kind == K_ACK) || (kind == K_ERRACK);
                    dbus_err   = (kind == K_ERR) || (kind == K_ERRACK);
                    dbus_rdata = (idx == 0) ? op.word0 : op.word1;
                    in_txn = 1'b0;
                end
                cyc++;
            end else begin
                in_txn = 1'b0;
            end
            if (!done) begin
                @(negedge clk);
                k++;
            end
        end
        exp_lat = (e.ntxn == 0) ? 1 : 1 + e.req_cycles;
        check({name, " done"},      32'(done),      32'd1);
        check({name, " latency"},   k,              exp_lat);
        check({name, " stall"},     stallc,         exp_lat);
        check({name, " reqcycles"}, reqc,           e.req_cycles);
        check({name, " ntxn"},      obs_ntxn,       e.ntxn);
        check({name, " bus"},       32'(bad),       32'd0);
        check({name, " rdata"},     obs_rdata,      e.rdata);
        check({name, " fault"},     32'(obs_fault), 32'(e.fault));
        check({name, " mis"},       32'(obs_mis),   32'(e.mis));
        @(negedge clk);
        #1;
        check({name, " pulse"},     32'(mb_wb__valid), 32'd0);
    endtask

    vec_t vecs[16];
    op_t  rop;
    logic seen;

    initial begin
        rst_n = 1'b0;
        ex_mb__valid = 1'b0; ex_mb__alu_y = '0; ex_mb__rs2_rdata = '0;
        ex_mb__dmem_width = 2'b00; ex_mb__dmem_zero_ext = 1'b0;
        ex_mb__dmem_read = 1'b0; ex_mb__dmem_write = 1'b0;
        dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = '0;

        //          addr          data          w     z     rd    wr    word0         word1         wt0 k0        wt1 k1
        vecs[0]  = mk_vec(mk_op(32'h100, 0, 2'b10, 0, 1, 0, 32'hDEADBEEF, 0, 0, K_ACK, 0, K_ACK),
                          32'hDEADBEEF, 0, 0, 1, 32'h100, 4'h0, 32'h0);
        vecs[1]  = mk_vec(mk_op(32'h203, 32'h123456A5, 2'b00, 0, 0, 1, 0, 0, 0, K_ACK, 0, K_ACK),
                          32'h0, 0, 0, 1, 32'h200, 4'b1000, 32'hA5000000);
        vecs[2]  = mk_vec(mk_op(32'h101, 0, 2'b00, 0, 1, 0, 32'h00008000, 0, 0, K_ACK, 0, K_ACK),
                          32'hFFFFFF80, 0, 0, 1, 32'h100, 4'h0, 32'h0);
        vecs[3]  = mk_vec(mk_op(32'h101, 0, 2'b00, 1, 1, 0, 32'h00008000, 0, 1, K_ACK, 0, K_ACK),
                          32'h00000080, 0, 0, 1, 32'h100, 4'h0, 32'h0);
        vecs[4]  = mk_vec(mk_op(32'h300, 0, 2'b10, 0, 1, 0, 32'h12345678, 0, 0, K_NONE, 0, K_ACK),
                          32'h0, 1, 0, 1, 32'h300, 4'h0, 32'h0);
        vecs[5]  = mk_vec(mk_op(32'h304, 0, 2'b10, 0, 1, 0, 32'h12345678, 0, 2, K_ERRACK, 0, K_ACK),
                          32'h0, 1, 0, 1, 32'h304, 4'h0, 32'h0);
        vecs[6]  = mk_vec(mk_op(32'h102, 0, 2'b10, 0, 1, 0, 32'hAABBCCDD, 32'h11223344, 0, K_ACK, 0, K_ACK),
                          SPLIT ? 32'h3344AABB : 32'h0, 0, !SPLIT, SPLIT ? 2 : 0, 32'h100, 4'h0, 32'h0);
        vecs[7]  = mk_vec(mk_op(32'h103, 0, 2'b01, 0, 1, 0, 32'h11223344, 32'h55667788, 1, K_ACK, 2, K_ACK),
                          SPLIT ? 32'hFFFF8811 : 32'h0, 0, !SPLIT, SPLIT ? 2 : 0, 32'h100, 4'h0, 32'h0);
        vecs[8]  = mk_vec(mk_op(32'h102, 0, 2'b01, 0, 1, 0, 32'h80FF1234, 0, 0, K_ACK, 0, K_ACK),
                          32'hFFFF80FF, 0, 0, 1, 32'h100, 4'h0, 32'h0);
        vecs[9]  = mk_vec(mk_op(32'h0, 32'hCAFEF00D, 2'b10, 0, 0, 1, 0, 0, 0, K_ACK, 0, K_ACK),
                          32'h0, 0, 0, 1, 32'h0, 4'hF, 32'hCAFEF00D);
        vecs[10] = mk_vec(mk_op(32'h101, 32'h1234BEEF, 2'b01, 0, 0, 1, 0, 0, 3, K_ACK, 0, K_ACK),
                          32'h0, 0, 0, 1, 32'h100, 4'b0110, 32'h34BEEF00);
        vecs[11] = mk_vec(mk_op(32'h80, 0, 2'b10, 0, 1, 0, 32'h01234567, 0, MAX_WAIT - 1, K_ACK, 0, K_ACK),
                          32'h01234567, 0, 0, 1, 32'h80, 4'h0, 32'h0);
        vecs[12] = mk_vec(mk_op(32'h1, 0, 2'b10, 0, 1, 0, 32'h99999999, 0, 0, K_ERR, 0, K_ACK),
                          32'h0, SPLIT, !SPLIT, SPLIT ? 1 : 0, 32'h0, 4'h0, 32'h0);
        vecs[13] = mk_vec(mk_op(32'hFFFFFFFE, 32'hA1B2C3D4, 2'b10, 0, 0, 1, 0, 0, 0, K_ACK, 1, K_ACK),
                          32'h0, 0, !SPLIT, SPLIT ? 2 : 0, 32'hFFFFFFFC, 4'b1100, 32'hC3D40000);
        vecs[14] = mk_vec(mk_op(32'h0, 32'h00000077, 2'b00, 0, 1, 1, 32'hFFFFFFFF, 0, 0, K_ACK, 0, K_ACK),
                          32'h0, 0, 0, 1, 32'h0, 4'b0001, 32'h00000077);
        vecs[15] = mk_vec(mk_op(32'h2, 0, 2'b01, 1, 1, 0, 32'h80FF1234, 0, 1, K_ERR, 0, K_ACK),
                          32'h0, 1, 0, 1, 32'h0, 4'h0, 32'h0);

        #12;
        check("reset stall", 32'(mb_ex__stall), 0);
        check("reset req",   32'(dbus_req),     0);
        check("reset we",    32'(dbus_we),      0);
        check("reset addr",  dbus_addr,         0);
        check("reset wstrb", 32'(dbus_wstrb),   0);
        check("reset wdata", dbus_wdata,        0);
        check("reset valid", 32'(mb_wb__valid), 0);
        check("reset rdata", mb_wb__rdata,      0);
        check("reset fault", 32'(mb_wb__fault), 0);
        check("reset mis",   32'(mb_wb__misaligned), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory instruction: ignored entirely.
        @(negedge clk);
        ex_mb__valid = 1'b1; ex_mb__dmem_read = 1'b0; ex_mb__dmem_write = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            seen |= mb_ex__stall | dbus_req | mb_wb__valid;
            @(negedge clk);
        end
        check("nonmem quiet", 32'(seen), 0);
        ex_mb__valid = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op);
            check($sformatf("vec%0d tbl_rdata", i), obs_rdata, vecs[i].rdata);
            check($sformatf("vec%0d tbl_fault", i), 32'(obs_fault), 32'(vecs[i].fault));
            check($sformatf("vec%0d tbl_mis", i), 32'(obs_mis), 32'(vecs[i].mis));
            check($sformatf("vec%0d tbl_ntxn", i), obs_ntxn, 32'(vecs[i].ntxn));
            if (vecs[i].ntxn != 0) begin
                check($sformatf("vec%0d tbl_addr0", i), obs_addr0, vecs[i].addr0);
                check($sformatf("vec%0d tbl_wstrb0", i), 32'(obs_wstrb0), 32'(vecs[i].wstrb0));
                check($sformatf("vec%0d tbl_wdata0", i), obs_wdata0, vecs[i].wdata0);
            end
        end

        // Reset in the middle of an outstanding access.
        @(negedge clk);
        ex_mb__valid = 1'b1; ex_mb__alu_y = 32'h400; ex_mb__dmem_width = 2'b10;
        ex_mb__dmem_read = 1'b1; ex_mb__dmem_write = 1'b0;
        @(negedge clk);
        #1;
        check("midrst req before", 32'(dbus_req), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ex_mb__valid = 1'b0;
        #1;
        check("midrst req dropped", 32'(dbus_req), 0);
        check("midrst no valid",    32'(mb_wb__valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            seen |= mb_wb__valid | dbus_req;
            @(negedge clk);
        end
        check("midrst quiet after", 32'(seen), 0);
        run_op("post_rst", mk_op(32'h400, 0, 2'b10, 0, 1, 0, 32'h5555AAAA, 0, 0, K_ACK, 0, K_ACK));
        check("post_rst rdata_const", obs_rdata, 32'h5555AAAA);

        for (int n = 0; n < 200; n++) begin
            int sel, r;
            rop = '0;
            rop.addr = $urandom;
            if ($urandom_range(0, 7) == 0) rop.addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            rop.data  = $urandom;
            rop.width = 2'($urandom_range(0, 2));
            rop.zext  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            rop.rd = (sel < 5) || (sel == 9);
            rop.wr = (sel >= 5);
            rop.word0 = $urandom;
            rop.word1 = $urandom;
            rop.wait0 = 8'($urandom_range(0, 3));
            rop.wait1 = 8'($urandom_range(0, 3));
            r = $urandom_range(0, 19);
            rop.kind0 = (r == 0) ? K_ERR : (r == 1) ? K_ERRACK : (r == 2) ? K_NONE : K_ACK;
            r = $urandom_range(0, 19);
            rop.kind1 = (r == 0) ? K_ERR : (r == 1) ? K_NONE : K_ACK;
            run_op($sformatf("rnd%0d", n), rop);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
